// File: rtl/bomb_scheduler.sv
// bomb_scheduler: owns every live bomb on the map.
//   Accepts tile-snapped placement requests, runs an 8-bit fuse per slot on the
//   tick timebase, and serialises expired bombs onto the single explosion
//   channel (IDLE -> FIRE -> BURN), one explosion per burn window.
//
// Parameters:
//   NUM_BOMBS   number of bomb slots (1..8)
//   FUSE_TICKS  fuse length in tick pulses (1..255)
//   BURN_CYCLES clk cycles the explosion channel is busy per fire (2..65535)
//   TILE_SHIFT  log2 of the tile size in pixels
//
// Optional build macro: CHAIN_REACTION_EN
//   When defined, the FIRE cycle forces every other live, non-pending bomb
//   inside the explosion cross (same row/column, within 3 tiles) to pending.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   tick                       one-cycle fuse timebase pulse
//   place_req, b_x, b_y        placement request with player position
//   place_ack, place_reject    one-cycle registered placement response
//   explosion_write_enable     one-cycle strobe on the FIRE cycle
//   exploding_bomb_x/_y        tile-aligned coordinates of the last grant
//   explosion_busy             high during FIRE and BURN
//   bomb_active                per-slot valid bits
//   bomb_xy_flat               per-slot {y,x}, slot i at [20i+19:20i]
module bomb_scheduler #(
  parameter int unsigned NUM_BOMBS   = 4,
  parameter int unsigned FUSE_TICKS  = 120,
  parameter int unsigned BURN_CYCLES = 256,
  parameter int unsigned TILE_SHIFT  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    tick,
  input  logic                    place_req,
  input  logic [9:0]              b_x,
  input  logic [9:0]              b_y,
  output logic                    place_ack,
  output logic                    place_reject,
  output logic                    explosion_write_enable,
  output logic [9:0]              exploding_bomb_x,
  output logic [9:0]              exploding_bomb_y,
  output logic                    explosion_busy,
  output logic [NUM_BOMBS-1:0]    bomb_active,
  output logic [NUM_BOMBS*20-1:0] bomb_xy_flat
);

  localparam int unsigned IDX_W   = (NUM_BOMBS > 1) ? $clog2(NUM_BOMBS) : 1;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned FUSE_W  = 8;
  localparam int unsigned BURN_W  = 16;
  localparam logic [COORD_W-1:0] SNAP_MASK = ~COORD_W'((1 << TILE_SHIFT) - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_BURN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BURN_W-1:0]   r_burn_cnt;
  logic [BURN_W-1:0]   w_burn_cnt_nxt;
  logic                w_grant;

  logic [NUM_BOMBS-1:0] r_valid;
  logic [NUM_BOMBS-1:0] r_pending;
  logic [FUSE_W-1:0]    r_fuse [NUM_BOMBS];
  logic [COORD_W-1:0]   r_x    [NUM_BOMBS];
  logic [COORD_W-1:0]   r_y    [NUM_BOMBS];

  logic [COORD_W-1:0] w_snap_x;
  logic [COORD_W-1:0] w_snap_y;
  logic               w_hit;
  logic               w_free_any;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_grant_idx;
  logic               w_accept;

  // Tile snap: clearing low bits can never overflow.
  assign w_snap_x = b_x & SNAP_MASK;
  assign w_snap_y = b_y & SNAP_MASK;

  // Slot scan on pre-edge state: occupancy hit, lowest free, lowest pending.
  always_comb begin
    w_hit       = 1'b0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    w_grant_idx = '0;
    for (int i = int'(NUM_BOMBS) - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
      if (r_pending[i]) begin
        w_grant_idx = IDX_W'(i);
      end
      if (r_valid[i] && (r_x[i] == w_snap_x) && (r_y[i] == w_snap_y)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign w_accept = place_req && w_free_any && !w_hit;

  // Explosion channel next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_burn_cnt_nxt = r_burn_cnt;
    w_grant        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|r_pending) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_FIRE;
        end
      end
      ST_FIRE: begin
        // FIRE + (BURN_CYCLES-1) BURN cycles + IDLE grant gives BURN_CYCLES+1 spacing.
        w_burn_cnt_nxt = BURN_W'(BURN_CYCLES - 2);
        w_state_nxt    = ST_BURN;
      end
      ST_BURN: begin
        if (r_burn_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_burn_cnt_nxt = r_burn_cnt - BURN_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Explosion channel state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_burn_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_burn_cnt <= w_burn_cnt_nxt;
    end
  end

`ifdef CHAIN_REACTION_EN
  localparam logic [COORD_W-1:0] CHAIN_RANGE = COORD_W'(3 << TILE_SHIFT);

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic [NUM_BOMBS-1:0] w_chain;

  // Slots inside the cross of the bomb firing this cycle.
  always_comb begin
    w_chain = '0;
    for (int i = 0; i < int'(NUM_BOMBS); i++) begin
      if ((r_state == ST_FIRE) && r_valid[i] && !r_pending[i] &&
          (((r_x[i] == exploding_bomb_x) &&
            (abs_diff(r_y[i], exploding_bomb_y) <= CHAIN_RANGE)) ||
           ((r_y[i] == exploding_bomb_y) &&
            (abs_diff(r_x[i], exploding_bomb_x) <= CHAIN_RANGE)))) begin
        w_chain[i] = 1'b1;
      end
    end
  end
`endif

  // Per-slot state: grant clears, placement loads, fuse counts down on tick.
  // Grant targets a valid slot and placement an invalid one, so they never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= '0;
      r_pending <= '0;
      for (int i = 0; i < int'(NUM_BOMBS); i++) begin
        r_fuse[i] <= '0;
        r_x[i]    <= '0;
        r_y[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NUM_BOMBS); i++) begin
        if (w_grant && (w_grant_idx == IDX_W'(i))) begin
          r_valid[i]   <= 1'b0;
          r_pending[i] <= 1'b0;
        end else if (w_accept && (w_free_idx == IDX_W'(i))) begin
          r_valid[i]   <= 1'b1;
          r_pending[i] <= 1'b0;
          r_fuse[i]    <= FUSE_W'(FUSE_TICKS);
          r_x[i]       <= w_snap_x;
          r_y[i]       <= w_snap_y;
`ifdef CHAIN_REACTION_EN
        end else if (w_chain[i]) begin
          r_fuse[i]    <= '0;
          r_pending[i] <= 1'b1;
`endif
        end else if (tick && r_valid[i] && !r_pending[i] && (r_fuse[i] != '0)) begin
          r_fuse[i] <= r_fuse[i] - FUSE_W'(1);
          if (r_fuse[i] == FUSE_W'(1)) begin
            r_pending[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Registered responses and explosion-channel outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      place_ack              <= 1'b0;
      place_reject           <= 1'b0;
      explosion_write_enable <= 1'b0;
      explosion_busy         <= 1'b0;
      exploding_bomb_x       <= '0;
      exploding_bomb_y       <= '0;
    end else begin
      place_ack              <= w_accept;
      place_reject           <= place_req && !w_accept;
      explosion_write_enable <= (w_state_nxt == ST_FIRE);
      explosion_busy         <= (w_state_nxt != ST_IDLE);
      if (w_grant) begin
        exploding_bomb_x <= r_x[w_grant_idx];
        exploding_bomb_y <= r_y[w_grant_idx];
      end
    end
  end

  assign bomb_active = r_valid;

  // Flatten slot coordinates for the sprite renderer.
  always_comb begin
    bomb_xy_flat = '0;
    for (int i = 0; i < int'(NUM_BOMBS); i++) begin
      bomb_xy_flat[20*i +: 20] = {r_y[i], r_x[i]};
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Scoreboard bench for bomb_scheduler (default parameters).
module tb_bomb_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic        place_req;
  logic [9:0]  b_x;
  logic [9:0]  b_y;
  logic        place_ack;
  logic        place_reject;
  logic        explosion_write_enable;
  logic [9:0]  exploding_bomb_x;
  logic [9:0]  exploding_bomb_y;
  logic        explosion_busy;
  logic [3:0]  bomb_active;
  logic [79:0] bomb_xy_flat;

  always #5 clk = ~clk;

  bomb_scheduler dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .tick                   (tick),
    .place_req              (place_req),
    .b_x                    (b_x),
    .b_y                    (b_y),
    .place_ack              (place_ack),
    .place_reject           (place_reject),
    .explosion_write_enable (explosion_write_enable),
    .exploding_bomb_x       (exploding_bomb_x),
    .exploding_bomb_y       (exploding_bomb_y),
    .explosion_busy         (explosion_busy),
    .bomb_active            (bomb_active),
    .bomb_xy_flat           (bomb_xy_flat)
  );

  typedef struct {
    logic       ack;
    logic [3:0] active;
  } place_exp_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         gap;
  } fire_exp_t;

  typedef struct {
    logic [3:0]  active;
    logic [79:0] xy;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic        busy;
  } state_exp_t;

  place_exp_t q_place[$];
  fire_exp_t  q_fire[$];
  state_exp_t q_state[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_fire = 0;
  logic done_req = 1'b0;
  logic mon_done = 1'b0;

`ifdef CHAIN_REACTION_EN
  localparam int CHAIN_GAP = 257;
`else
  localparam int CHAIN_GAP = 300;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT presents a response.
  always @(negedge clk) begin
    place_exp_t pe;
    fire_exp_t  fe;
    state_exp_t se;
    if (place_ack || place_reject) begin
      n_checks++;
      if (q_place.size() == 0) begin
        n_errors++;
        $display("FAIL place_unexpected: ack=%0b rej=%0b, required no response", place_ack, place_reject);
      end else begin
        pe = q_place.pop_front();
        if (place_ack !== pe.ack || place_reject !== !pe.ack || bomb_active !== pe.active) begin
          n_errors++;
          $display("FAIL place_resp @%0d: ack=%0b rej=%0b active=%b, required ack=%0b active=%b",
                   cyc, place_ack, place_reject, bomb_active, pe.ack, pe.active);
        end
      end
    end
    if (explosion_write_enable) begin
      n_checks++;
      if (q_fire.size() == 0) begin
        n_errors++;
        $display("FAIL fire_unexpected @%0d: x=%0d y=%0d, required no fire", cyc, exploding_bomb_x, exploding_bomb_y);
      end else begin
        fe = q_fire.pop_front();
        if (exploding_bomb_x !== fe.x || exploding_bomb_y !== fe.y ||
            (fe.gap != 0 && (cyc - last_fire) != fe.gap)) begin
          n_errors++;
          $display("FAIL fire @%0d: x=%0d y=%0d gap=%0d, required x=%0d y=%0d gap=%0d",
                   cyc, exploding_bomb_x, exploding_bomb_y, cyc - last_fire, fe.x, fe.y, fe.gap);
        end
      end
      last_fire = cyc;
    end
    if (q_state.size() > 0) begin
      se = q_state.pop_front();
      n_checks++;
      if (bomb_active !== se.active || bomb_xy_flat !== se.xy || exploding_bomb_x !== se.ex ||
          exploding_bomb_y !== se.ey || explosion_busy !== se.busy || explosion_write_enable !== 1'b0 ||
          place_ack !== 1'b0 || place_reject !== 1'b0) begin
        n_errors++;
        $display("FAIL state @%0d: active=%b xy=%h ex=%0d ey=%0d busy=%0b we=%0b ack=%0b rej=%0b, required active=%b xy=%h ex=%0d ey=%0d busy=%0b we=0 ack=0 rej=0",
                 cyc, bomb_active, bomb_xy_flat, exploding_bomb_x, exploding_bomb_y, explosion_busy,
                 explosion_write_enable, place_ack, place_reject, se.active, se.xy, se.ex, se.ey, se.busy);
      end
    end
    if (done_req && !mon_done) begin
      n_checks++;
      if (q_place.size() != 0 || q_fire.size() != 0 || q_state.size() != 0) begin
        n_errors++;
        $display("FAIL leftover: place=%0d fire=%0d state=%0d outstanding, required 0 0 0",
                 q_place.size(), q_fire.size(), q_state.size());
      end
      mon_done = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic place(input logic [9:0] x, input logic [9:0] y, input logic ack, input logic [3:0] act);
    q_place.push_back('{ack, act});
    b_x       = x;
    b_y       = y;
    place_req = 1'b1;
    step();
    place_req = 1'b0;
  endtask

  task automatic ticks(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat (period - 1) step();
    end
  endtask

  task automatic expect_state(input logic [3:0] act, input logic [79:0] xy, input logic [9:0] ex,
                              input logic [9:0] ey, input logic busy);
    q_state.push_back('{act, xy, ex, ey, busy});
  endtask

  function automatic logic [19:0] yx(input int x, input int y);
    return {10'(y), 10'(x)};
  endfunction

  initial begin
    reset_n   = 1'b0;
    tick      = 1'b0;
    place_req = 1'b0;
    b_x       = '0;
    b_y       = '0;
    repeat (3) step();
    expect_state(4'b0000, 80'd0, 10'd0, 10'd0, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // Single bomb: snap, fuse, fire.
    place(10'd37, 10'd50, 1'b1, 4'b0001);
    step();
    expect_state(4'b0001, {60'd0, yx(32, 48)}, 10'd0, 10'd0, 1'b0);
    q_fire.push_back('{10'd32, 10'd48, 0});
    ticks(120, 2);
    repeat (5) step();
    expect_state(4'b0000, {60'd0, yx(32, 48)}, 10'd32, 10'd48, 1'b1);
    repeat (300) step();

    // Same-tile reject, full reject, simultaneous expiry, place on grant edge.
    place(10'd37, 10'd50, 1'b1, 4'b0001);
    place(10'd40, 10'd60, 1'b0, 4'b0001);
    place(10'd64, 10'd48, 1'b1, 4'b0011);
    place(10'd96, 10'd48, 1'b1, 4'b0111);
    place(10'd128, 10'd48, 1'b1, 4'b1111);
    place(10'd160, 10'd48, 1'b0, 4'b1111);
    q_fire.push_back('{10'd32, 10'd48, 0});
    q_fire.push_back('{10'd64, 10'd48, 257});
    q_fire.push_back('{10'd96, 10'd48, 257});
    ticks(119, 2);
    tick = 1'b1;
    step();
    tick = 1'b0;
    place(10'd320, 10'd320, 1'b0, 4'b1110);
    place(10'd320, 10'd320, 1'b1, 4'b1111);
    repeat (620) step();
    expect_state(4'b1001, {yx(128, 48), yx(96, 48), yx(64, 48), yx(320, 320)}, 10'd96, 10'd48, 1'b1);
    step();

    // Reset in the middle of a burn window with two live slots.
    reset_n = 1'b0;
    expect_state(4'b0000, 80'd0, 10'd0, 10'd0, 1'b0);
    repeat (2) step();
    reset_n = 1'b1;
    step();
    expect_state(4'b0000, 80'd0, 10'd0, 10'd0, 1'b0);
    step();
    ticks(130, 2);
    expect_state(4'b0000, 80'd0, 10'd0, 10'd0, 1'b0);
    step();

    // Neighbouring bombs 30 ticks apart: chained or independent.
    place(10'd32, 10'd48, 1'b1, 4'b0001);
    ticks(30, 10);
    place(10'd64, 10'd48, 1'b1, 4'b0011);
    q_fire.push_back('{10'd32, 10'd48, 0});
    q_fire.push_back('{10'd64, 10'd48, CHAIN_GAP});
    ticks(90, 10);
    ticks(35, 10);
    repeat (300) step();
    expect_state(4'b0000, {40'd0, yx(64, 48), yx(32, 48)}, 10'd64, 10'd48, 1'b0);
    step();

    done_req = 1'b1;
    for (int k = 0; k < 10 && !mon_done; k++) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bomb_scheduler.md
Name: bomb_scheduler

Overview:
- Owns every live bomb on the map: accepts placement requests from the player, runs per-bomb fuse timers, and sequences expired bombs onto the single explosion datapath.
- Drives the explosion block's new-explosion strobe and exploding-bomb coordinates. Only one explosion is issued at a time; later expiries queue until the current burn window ends.
- Sits between player/input logic and the explosion renderer. Also exports slot state for the bomb sprite renderer.

Parameters:
- NUM_BOMBS, 4, number of bomb slots (1..8).
- FUSE_TICKS, 120, fuse length in tick pulses (1..255).
- BURN_CYCLES, 256, clk cycles the explosion channel stays busy after a fire (2..65535).
- TILE_SHIFT, 4, log2 of tile size; 16-px grid.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle fuse timebase pulse (frame tick).
- place_req  in  1  one-cycle player bomb request (C).
- b_x  in  10  bomberman x, sampled with place_req.
- b_y  in  10  bomberman y, sampled with place_req.
- place_ack  out  1  one-cycle pulse: bomb accepted.
- place_reject  out  1  one-cycle pulse: slots full or tile occupied.
- explosion_write_enable  out  1  one-cycle strobe to the explosion block.
- exploding_bomb_x  out  10  tile-aligned x of the current/last explosion.
- exploding_bomb_y  out  10  tile-aligned y of the current/last explosion.
- explosion_busy  out  1  high while in FIRE or BURN.
- bomb_active  out  NUM_BOMBS  slot valid bits.
- bomb_xy_flat  out  NUM_BOMBS*20  per-slot {y,x}; slot i occupies bits [20i+19:20i].

Behaviour:
- Reset (async, reset_n low): all slots invalid, fuse counters 0, pending 0. FSM to IDLE. Every output is 0, including exploding_bomb_x/y and bomb_xy_flat.
- Placement:
  - The request is evaluated on the clk edge where place_req=1.
  - Coordinates are snapped to the tile: x = b_x with the low TILE_SHIFT bits cleared; same for y.
  - Reject if the snapped tile matches any valid slot, or if no slot is free.
  - Otherwise write the lowest-index free slot: valid=1, fuse=FUSE_TICKS, pending=0.
  - place_ack or place_reject is registered and pulses exactly 1 cycle after the request edge. bomb_active updates on that same cycle.
- Free-slot evaluation uses state from before the edge. A slot freed by FIRE on the same edge is not reusable until the next request.
- Fuse:
  - On tick=1, each valid, non-pending slot with fuse>0 decrements.
  - When fuse reaches 0, pending=1 on that same edge.
  - A slot placed on an edge where tick=1 does not decrement on that edge.
- FSM states: IDLE, FIRE, BURN.
  - IDLE: if any slot is pending, pick the lowest pending index, latch its x/y into exploding_bomb_x/y, clear that slot (valid=0, pending=0), and go to FIRE. Otherwise stay in IDLE.
  - FIRE, 1 cycle: explosion_write_enable=1. Load burn counter = BURN_CYCLES-2, go to BURN.
  - BURN: decrement the counter; at 0 go to IDLE.
- Fire spacing: FIRE→FIRE distance is exactly BURN_CYCLES+1 cycles when bombs are queued back to back.
- explosion_busy=1 in FIRE and BURN. exploding_bomb_x/y hold their value until the next grant.
- Pending slots keep valid=1 and stay visible to the renderer until granted. Their fuse stays 0 and they are not re-decremented.
- Simultaneous expiries: serviced in ascending index order, one per burn window.
- Simultaneous place and grant on the same edge: both occur independently.
- Width rules:
  - Snapping never overflows.
  - Fuse is 8-bit; burn counter is 16-bit.
  - No screen bounds checking here; the explosion block owns clipping.

Optional Feature:
- Macro: CHAIN_REACTION_EN.
- Defined: on the FIRE cycle, every other valid, non-pending slot gets fuse=0 and pending=1 on the next edge if it lies within the explosion cross:
  - same x and |dy| ≤ 3 tiles, or
  - same y and |dx| ≤ 3 tiles.
- Chained slots are then serviced in normal ascending order.
- Not defined: no chaining; fuses run independently. Port list is identical in both builds.

Test Plan:
- Reset → all outputs 0 after reset_n low mid-BURN with 2 slots valid; after release, no write_enable until a new bomb expires.
- Place: b_x=37, b_y=50 → place_ack next cycle, slot0 {y,x}={48,32}. After 120 ticks: write_enable 1 cycle, exploding_bomb_x=32, _y=48, bomb_active=0.
- Second place at b_x=40, b_y=60 (same tile) → place_reject; 5th distinct placement with 4 live → place_reject.
- Two bombs placed with tick=0 in between expire on the same tick → slot0 fires first; slot1 fires exactly BURN_CYCLES+1 cycles later.
- place_req on the edge slot0 is granted, with slots1-3 full → reject. A placement on the following cycle → ack into slot0.
- CHAIN_REACTION_EN: bombs at (32,48) and (64,48), the second placed 30 ticks later → both fire one burn window apart, second before its own fuse ends. Without the macro → second fires 30 ticks after the first.
